// File: rtl/dct_seq_ctrl.sv
// Read/MAC/output sequencer for the NxN DCT/IDCT datapath; all state moves on the falling clock edge.
// Optional performance counters (cyc_cnt, stall_cnt) are built when DCT_SEQ_CTRL_PERF_EN is defined.
module dct_seq_ctrl #(
  parameter int LOG2N  = 3,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 abort,
  input  logic                 out_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 mac_rst_n,
  output logic                 rd_en,
  output logic                 mac_en,
  output logic [LOG2N-1:0]     outer_i,
  output logic [LOG2N-1:0]     outer_j,
  output logic [LOG2N-1:0]     inner_i,
  output logic [LOG2N-1:0]     inner_j,
  output logic [2*LOG2N-1:0]   addr,
  output logic [2*LOG2N-1:0]   out_addr,
  output logic                 out_valid,
  output logic                 mode_q
`ifdef DCT_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]          cyc_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_ACC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [LOG2N-1:0] IDX_MAX  = '1;
  localparam logic [LOG2N-1:0] IDX_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};
  localparam logic [2:0]       DRN_LAST = 3'(RD_LAT - 1);

  logic [2:0]        r_state;
  logic              r_mode;
  logic [LOG2N-1:0]  r_outer_i;
  logic [LOG2N-1:0]  r_outer_j;
  logic [LOG2N-1:0]  r_inner_i;
  logic [LOG2N-1:0]  r_inner_j;
  logic [2:0]        r_drn;
  logic [RD_LAT-1:0] r_rd_pipe;

  logic w_busy;
  logic w_rd_en;
  logic w_abort;

  assign w_busy  = (r_state != S_IDLE);
  assign w_rd_en = (r_state == S_ACC);
  assign w_abort = w_busy && abort;

  always_ff @(negedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_outer_i <= '0;
      r_outer_j <= '0;
      r_inner_i <= '0;
      r_inner_j <= '0;
      r_drn     <= '0;
      r_rd_pipe <= '0;
    end else begin
      // mac_en is the read strobe delayed RD_LAT edges; abort drops reads still in flight
      if (w_abort) begin
        r_rd_pipe <= '0;
      end else begin
        r_rd_pipe[0] <= w_rd_en;
        for (int k = 1; k < RD_LAT; k++) r_rd_pipe[k] <= r_rd_pipe[k-1];
      end

      if (w_abort) begin
        r_state   <= S_IDLE;
        r_outer_i <= '0;
        r_outer_j <= '0;
        r_inner_i <= '0;
        r_inner_j <= '0;
        r_drn     <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_mode    <= mode;
              r_outer_i <= '0;
              r_outer_j <= '0;
              r_inner_i <= '0;
              r_inner_j <= '0;
              r_drn     <= '0;
              r_state   <= S_CLR;
            end
          end
          S_CLR: begin
            r_inner_i <= '0;
            r_inner_j <= '0;
            r_state   <= S_ACC;
          end
          S_ACC: begin
            r_inner_j <= r_inner_j + IDX_ONE;
            if (r_inner_j == IDX_MAX) begin
              r_inner_i <= r_inner_i + IDX_ONE;
              if (r_inner_i == IDX_MAX) begin
                r_drn   <= '0;
                r_state <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            if (r_drn == DRN_LAST) r_state <= S_OUT;
            else                   r_drn   <= r_drn + 3'd1;
          end
          S_OUT: begin
            // the last output wraps the outer indices back to 0 on its way to DONE
            if (out_ack) begin
              r_outer_j <= r_outer_j + IDX_ONE;
              if (r_outer_j == IDX_MAX) r_outer_i <= r_outer_i + IDX_ONE;
              r_state <= ((r_outer_i == IDX_MAX) && (r_outer_j == IDX_MAX)) ? S_DONE : S_CLR;
            end
          end
          S_DONE: begin
            r_outer_i <= '0;
            r_outer_j <= '0;
            r_state   <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef DCT_SEQ_CTRL_PERF_EN
  logic [31:0] r_cyc_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(negedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_cyc_cnt   <= '0;
      r_stall_cnt <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_cyc_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_busy && (r_cyc_cnt != 32'hFFFF_FFFF)) r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if ((r_state == S_OUT) && !out_ack && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign cyc_cnt   = r_cyc_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

  assign busy      = w_busy;
  assign done      = (r_state == S_DONE);
  assign mac_rst_n = (r_state != S_IDLE) && (r_state != S_CLR);
  assign rd_en     = w_rd_en;
  assign mac_en    = r_rd_pipe[RD_LAT-1];
  assign out_valid = (r_state == S_OUT);
  assign outer_i   = r_outer_i;
  assign outer_j   = r_outer_j;
  assign inner_i   = r_inner_i;
  assign inner_j   = r_inner_j;
  assign addr      = {r_inner_i, r_inner_j};
  assign out_addr  = {r_outer_i, r_outer_j};
  assign mode_q    = r_mode;

endmodule
